// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - looping instruction issuer over a local program memory with consumer back-pressure
// Optional feature macro: INSTR_SKIP_NOP_EN (entries with OPVALID/MSB clear are consumed silently)
module instr_issuer #(
  parameter int BIT_INSTR = 32,
  parameter int ADDR_W    = 10
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [BIT_INSTR-1:0] i_wr_data,
  input  logic                 i_start,
  input  logic [ADDR_W:0]      i_length,
  input  logic [7:0]           i_repeat,
  input  logic                 instr_stall,
  output logic [BIT_INSTR-1:0] o_Instr,
  output logic                 o_instr_pulse,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_W-1:0]    o_rd_ptr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state, state_nxt;
  logic [BIT_INSTR-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0]    ptr;
  logic [ADDR_W:0]      len_q;
  logic [7:0]           rep_q;
  logic [7:0]           pass;
  logic [BIT_INSTR-1:0] rd_word;
  logic                 start_ok;
  logic                 consume;
  logic                 last_entry;
  logic                 last_pass;
  logic                 emit;

  assign rd_word    = mem[ptr];
  assign start_ok   = (state == IDLE) && i_start;
  assign consume    = (state == ISSUE) && !instr_stall;
  assign last_entry = ({1'b0, ptr} == (len_q - (ADDR_W+1)'(1)));
  assign last_pass  = (pass == (rep_q - 8'd1));
  assign o_rd_ptr   = ptr;

`ifdef INSTR_SKIP_NOP_EN
  // A NOP entry still advances the pointer and counts toward the pass length.
  assign emit = consume && rd_word[BIT_INSTR-1];
`else
  assign emit = consume;
`endif

  // Program memory is only writable while idle and deliberately has no reset.
  always_ff @(posedge CLK) begin
    if (i_wr_en && (state == IDLE)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = (i_length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (consume && last_entry && last_pass) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == ISSUE);
    o_done = (state == DONE);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ptr           <= '0;
      pass          <= '0;
      len_q         <= '0;
      rep_q         <= '0;
      o_Instr       <= '0;
      o_instr_pulse <= 1'b0;
    end else begin
      o_instr_pulse <= emit;
      if (emit) begin
        o_Instr <= rd_word;
      end
      if (start_ok) begin
        len_q <= i_length;
        rep_q <= (i_repeat == 8'd0) ? 8'd1 : i_repeat;
        ptr   <= '0;
        pass  <= '0;
      end else if (consume) begin
        // Wrap straight back to entry 0 so consecutive passes have no bubble.
        if (last_entry) begin
          ptr <= '0;
          if (!last_pass) begin
            pass <= pass + 8'd1;
          end
        end else begin
          ptr <= ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// tb/tb_instr_issuer.sv - scoreboard bench for instr_issuer
`timescale 1ns/1ps
module tb_instr_issuer;
  localparam int BI = 32;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RSTb = 1'b1;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [BI-1:0] i_wr_data = '0;
  logic          i_start = 1'b0;
  logic [AW:0]   i_length = '0;
  logic [7:0]    i_repeat = '0;
  logic          instr_stall = 1'b0;
  logic [BI-1:0] o_Instr;
  logic          o_instr_pulse;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_rd_ptr;

  instr_issuer #(.BIT_INSTR(BI), .ADDR_W(AW)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_length(i_length), .i_repeat(i_repeat),
    .instr_stall(instr_stall),
    .o_Instr(o_Instr), .o_instr_pulse(o_instr_pulse), .o_busy(o_busy),
    .o_done(o_done), .o_rd_ptr(o_rd_ptr)
  );

  always #5 CLK = ~CLK;

  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  logic          stall_seen = 1'b0;
  logic [BI-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) stall_seen = instr_stall;

  // Monitor: pops the scoreboard on every issued word and audits each completion.
  always @(negedge CLK) begin
    if (RSTb && o_instr_pulse) begin
      chk("pulse_after_stalled_edge", stall_seen, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got %0h expected none", o_Instr);
      end else begin
        chk("instr", o_Instr, exp_q.pop_front());
      end
    end
    if (RSTb && o_done) begin
      done_cnt++;
      chk("words_pending_at_done", exp_q.size(), 0);
    end
  end

  task automatic wr(input int a, input logic [BI-1:0] d);
    i_wr_en = 1'b1;
    i_wr_addr = a[AW-1:0];
    i_wr_data = d;
    @(posedge CLK);
    #1 i_wr_en = 1'b0;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'h8000_0000 + first + i);
  endtask

  task automatic run(input int len, input int rep, input int exp_cycles,
                     input int stall_at, input int stall_len, input bit glitch);
    int k;
    i_length = len[AW:0];
    i_repeat = rep[7:0];
    i_start = 1'b1;
    @(posedge CLK);
    #1 i_start = 1'b0;
    i_wr_en = 1'b0;
    @(negedge CLK);
    k = 0;
    while (!o_done && k < 200) begin
      if (k == stall_at) instr_stall = 1'b1;
      if (k == stall_at + stall_len) instr_stall = 1'b0;
      if (glitch && k == 1) begin
        i_start = 1'b1; i_length = 1; i_wr_en = 1'b1; i_wr_addr = 0; i_wr_data = 32'hDEAD_BEEF;
      end
      if (glitch && k == 2) begin
        i_start = 1'b0; i_wr_en = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    chk("cycles_to_done", k, exp_cycles);
    instr_stall = 1'b0;
    @(negedge CLK);
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", o_busy, 0);
  endtask

  initial begin
    int d0;
    #3 RSTb = 1'b0;
    #1;
    chk("rst_instr", o_Instr, 0);
    chk("rst_pulse", o_instr_pulse, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ptr", o_rd_ptr, 0);
    repeat (2) @(negedge CLK);
    RSTb = 1'b1;
    for (int i = 0; i < 8; i++) wr(i, 32'h8000_0001 + i);

    push_seq(1, 4); run(4, 1, 4, -1, 0, 1);
    push_seq(1, 4); run(4, 1, 7, 2, 3, 0);
    push_seq(1, 3); push_seq(1, 3); run(3, 2, 6, -1, 0, 0);
    push_seq(1, 2); run(2, 0, 2, -1, 0, 0);
    run(0, 5, 0, -1, 0, 0);
    push_seq(1, 8); push_seq(1, 8); run(8, 2, 16, -1, 0, 0);
    chk("ptr_wrap_full_depth", o_rd_ptr, 0);

    i_wr_en = 1'b1; i_wr_addr = 0; i_wr_data = 32'h8000_00A1;
    exp_q.push_back(32'h8000_00A1); push_seq(2, 1);
    run(2, 1, 2, -1, 0, 0);
    wr(0, 32'h8000_0001);

    push_seq(1, 4);
    i_length = 4; i_repeat = 1; i_start = 1'b1;
    @(posedge CLK);
    #1 i_start = 1'b0;
    repeat (3) @(negedge CLK);
    d0 = done_cnt;
    #2 RSTb = 1'b0;
    #1;
    chk("abort_instr", o_Instr, 0);
    chk("abort_pulse", o_instr_pulse, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_ptr", o_rd_ptr, 0);
    chk("abort_words_left", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    chk("no_done_on_abort", done_cnt, d0);
    RSTb = 1'b1;
    push_seq(1, 4); run(4, 1, 4, -1, 0, 0);

    wr(1, 32'h0000_0000);
    exp_q.push_back(32'h8000_0001);
`ifndef INSTR_SKIP_NOP_EN
    exp_q.push_back(32'h0000_0000);
`endif
    push_seq(3, 2);
    run(4, 1, 4, -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 SHALL have parameter BIT_INSTR, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 10, program-memory address width; depth = 2^ADDR_W.
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RSTb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_wr_en  input  1  program-memory write strobe.
REQ-006 SHALL have port i_wr_addr  input  ADDR_W  write address.
REQ-007 SHALL have port i_wr_data  input  BIT_INSTR  write data.
REQ-008 SHALL have port i_start  input  1  start issuing, sampled in IDLE only.
REQ-009 SHALL have port i_length  input  ADDR_W+1  entries per pass, 0..2^ADDR_W.
REQ-010 SHALL have port i_repeat  input  8  pass count; 0 treated as 1.
REQ-011 SHALL have port instr_stall  input  1  consumer back-pressure.
REQ-012 SHALL have port o_Instr  output  BIT_INSTR  issued instruction, registered.
REQ-013 SHALL have port o_instr_pulse  output  1  one-cycle valid strobe per issued word.
REQ-014 SHALL have port o_busy  output  1  high in ISSUE.
REQ-015 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port o_rd_ptr  output  ADDR_W  current read pointer.

Function
REQ-017 SHALL implement states IDLE, ISSUE, DONE.
REQ-018 SHALL write i_wr_data to mem[i_wr_addr] on i_wr_en only in IDLE; writes in ISSUE/DONE ignored.
REQ-019 SHALL, in IDLE with i_start=1, latch i_length and i_repeat, clear ptr and pass counter, enter ISSUE next cycle; latched i_length=0 enters DONE instead, zero pulses.
REQ-020 SHALL, in ISSUE with instr_stall=0 at a rising edge, load o_Instr<=mem[ptr], assert o_instr_pulse for that cycle only, advance ptr.
REQ-021 SHALL, with instr_stall=1, hold ptr, hold o_Instr, drive o_instr_pulse=0.
REQ-022 SHALL, when entry ptr==length-1 is consumed: if pass<repeat-1, ptr<=0 and pass++, no bubble; else enter DONE.
REQ-023 SHALL, in DONE, assert o_done for exactly one cycle, then return to IDLE.
REQ-024 SHALL hold o_Instr at last issued value outside issue cycles.
REQ-025 SHALL ignore i_start outside IDLE.
REQ-026 SHALL, with write and start in the same IDLE cycle, commit the write before the first read.
REQ-027 SHALL issue at most one word per cycle; total pulses = length*max(repeat,1) with macro absent.
REQ-028 SHALL, for length=2^ADDR_W, wrap ptr to 0 with no overflow.

Reset
REQ-029 SHALL on RSTb=0 immediately set state IDLE, ptr=0, pass=0, o_Instr=0, o_instr_pulse=0, o_busy=0, o_done=0.
REQ-030 SHALL abort an in-progress pass on mid-operation reset without o_done; memory contents not reset.

Configuration
REQ-031 SHALL honour macro INSTR_SKIP_NOP_EN: defined -> in ISSUE with instr_stall=0, entry with MSB (OPVALID)=0 advances ptr without pulse and without updating o_Instr; still counts toward length.
REQ-032 SHALL, without INSTR_SKIP_NOP_EN, issue every entry regardless of MSB.

Verification
REQ-033 SHALL verify: load 4 words 0x8000_0001..0x8000_0004, length=4, repeat=1, start, no stall -> 4 consecutive pulses, values in order, o_done 1 cycle after last.
REQ-034 SHALL verify: same program, instr_stall high 3 cycles after second pulse -> no pulse during stall, third word issued first unstalled edge, no loss/duplication.
REQ-035 SHALL verify: length=3, repeat=2 -> 6 pulses, sequence 1,2,3,1,2,3, no gap between passes.
REQ-036 SHALL verify: length=0, start -> zero pulses, o_done one cycle later; i_start during ISSUE ignored.
REQ-037 SHALL verify: RSTb low mid-pass -> outputs zero asynchronously, no o_done; restart reissues from entry 0.
REQ-038 SHALL verify: INSTR_SKIP_NOP_EN defined, entry 1 = 0x0000_0000 in 4-word program -> 3 pulses, o_done after 4 entries consumed; undefined -> 4 pulses.
